seq_mul_unit: RTL and testbench

//  - Parametrised shift-add sequential multiplier: WIDTH x WIDTH -> 2*WIDTH product, one add-shift per clock.
//  - Generalises the fixed 4-bit product/accumulator register bank: adds the controller, iteration counter,

---
 rtl/seq_mul_pkg.sv | 24 ++
 rtl/seq_mul_regbank_n.sv | 48 ++++
 rtl/seq_mul_unit.sv | 111 +++++++++++
 tb/tb_seq_mul_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// ============================================================================
//  Module      : seq_mul_pkg
//  Description : Shared constants for the shift-add sequential multiplier.
//                Provides the state encoding, default width and counter sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_mul_pkg;

    localparam int c_default_width = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter must hold the value WIDTH itself, hence one bit beyond clog2.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_mul_regbank_n.sv
// ============================================================================
//  Module      : seq_mul_regbank_n
//  Description : {cy, acc, q} product register with the conditional adder;
//                performs one add-then-shift-right step per enabled cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mul_regbank_n #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   q_init,
    output logic [2*WIDTH-1:0] prod_next
);

    logic               r_cy;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_addend;

    assign w_addend  = r_q[0] ? mcand : '0;
    assign w_sum     = {r_cy, r_acc} + {1'b0, w_addend};
    // Value the register takes after this cycle's add and shift.
    assign prod_next = {w_sum, r_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cy  <= 1'b0;
            r_acc <= '0;
            r_q   <= '0;
        end else if (load) begin
            r_cy  <= 1'b0;
            r_acc <= '0;
            r_q   <= q_init;
        end else if (shift) begin
            {r_cy, r_acc, r_q} <= {1'b0, w_sum, r_q[WIDTH-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_mul_unit.sv
// ============================================================================
//  Module      : seq_mul_unit
//  Description : WIDTH x WIDTH sequential shift-add multiplier with
//                start/busy/done handshake and held result register.
//                Define SEQ_MUL_SIGNED_EN for two's complement operands.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mul_unit
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int               CNT_W      = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_p;
    logic               w_accept;
    logic               w_shift;
    logic [WIDTH-1:0]   w_load_a;
    logic [WIDTH-1:0]   w_load_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_result;

    assign w_accept = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_shift  = (r_state == ST_RUN);

`ifdef SEQ_MUL_SIGNED_EN
    logic r_sgn;

    // Magnitudes as unsigned WIDTH bits: -2^(WIDTH-1) maps to 2^(WIDTH-1).
    assign w_load_a = a[WIDTH-1] ? -a : a;
    assign w_load_b = b[WIDTH-1] ? -b : b;
    assign w_result = r_sgn ? -w_prod : w_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sgn <= 1'b0;
        end else if (w_accept) begin
            r_sgn <= a[WIDTH-1] ^ b[WIDTH-1];
        end
    end
`else
    assign w_load_a = a;
    assign w_load_b = b;
    assign w_result = w_prod;
`endif

    seq_mul_regbank_n #(
        .WIDTH     (WIDTH)
    ) u_regbank (
        .clk       (clk),
        .rst       (rst),
        .load      (w_accept),
        .shift     (w_shift),
        .mcand     (r_mcand),
        .q_init    (w_load_b),
        .prod_next (w_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mcand <= '0;
            r_p     <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_mcand <= w_load_a;
                        r_cnt   <= c_cnt_init;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_p     <= w_result;
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign p    = r_p;

endmodule

`default_nettype wire

// File: tb/tb_seq_mul_unit.sv
// ============================================================================
//  Module      : tb_seq_mul_unit
//  Description : Self-checking bench for seq_mul_unit (WIDTH=4) against a
//                cycle-count behavioural model plus literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_mul_unit;

    localparam int W = 4;

`ifdef SEQ_MUL_SIGNED_EN
    localparam logic [2*W-1:0] c_exp_max = 8'h01;  // (-1)*(-1)
    localparam logic [2*W-1:0] c_exp_b2b = 8'h14;  // (-4)*(-5)
`else
    localparam logic [2*W-1:0] c_exp_max = 8'hE1;  // 15*15
    localparam logic [2*W-1:0] c_exp_b2b = 8'h84;  // 12*11
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_mul_unit #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    function automatic logic [2*W-1:0] model_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        longint lx;
        longint ly;
`ifdef SEQ_MUL_SIGNED_EN
        lx = longint'($signed(x));
        ly = longint'($signed(y));
`else
        lx = longint'(x);
        ly = longint'(y);
`endif
        return (2*W)'(lx * ly);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: remaining busy cycles, one-cycle done flag, held product.
    int             m_left = 0;
    logic           m_done = 1'b0;
    logic [2*W-1:0] m_p    = '0;
    logic [2*W-1:0] m_pend = '0;
    bit             chk_en = 1'b0;

    always @(posedge clk) begin
        chk_en <= 1'b1;
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_p    <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) m_p <= m_pend;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_pend <= model_mul(a, b);
                m_left <= W;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_busy", 32'(busy), 32'(m_left > 0));
            chk("model_done", 32'(done), 32'(m_done));
            chk("model_p", 32'(p), 32'(m_p));
        end
    end

    task automatic wait_done(input string nm, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 20);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout: got done=%b expected done=1 within 20 cycles", nm, done);
        end
    endtask

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [2*W-1:0] exp, input string nm);
        int n;
        @(posedge clk); #2 start = 1'b1; a = x; b = y;
        @(posedge clk); #2 start = 1'b0;
        wait_done(nm, n);
        chk({nm, "_latency"}, 32'(n), 32'(W + 1));
        chk({nm, "_p"}, 32'(p), 32'(exp));
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset_p", 32'(p), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);

        op(4'd15, 4'd15, c_exp_max, "max");
        op(4'd0, 4'd9, 8'h00, "zero");
        op(4'd7, 4'd1, 8'h07, "identity");
        repeat (4) @(negedge clk);

        // Second start lands in RUN cycle 2 and must be ignored.
        @(posedge clk); #2 start = 1'b1; a = 4'd3; b = 4'd5;
        @(posedge clk); #2 start = 1'b0;
        @(posedge clk); #2 start = 1'b1; a = 4'd15; b = 4'd15;
        @(posedge clk); #2 start = 1'b0;
        wait_done("busy_start", n);
        chk("busy_start_p", 32'(p), 32'h0F);
        repeat (8) @(negedge clk);

        // Reset in the middle of an operation.
        @(posedge clk); #2 start = 1'b1; a = 4'd9; b = 4'd9;
        @(posedge clk); #2 start = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("midrst_p", 32'(p), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        repeat (8) @(negedge clk);
        op(4'd2, 4'd3, 8'h06, "after_rst");

        // Back-to-back: start held during the DONE cycle.
        op(4'd5, 4'd3, 8'h0F, "b2b_first");
        start = 1'b1; a = 4'd12; b = 4'd11;
        @(posedge clk); #2 start = 1'b0;
        @(negedge clk);
        chk("b2b_busy", 32'(busy), 32'h1);
        wait_done("b2b", n);
        chk("b2b_latency", 32'(n), 32'(W));
        chk("b2b_p", 32'(p), 32'(c_exp_b2b));

`ifdef SEQ_MUL_SIGNED_EN
        op(4'h8, 4'h8, 8'h40, "neg8_neg8");
        op(4'hD, 4'h5, 8'hF1, "neg3_pos5");
`endif
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
